// File: rtl/jt51_regs_pkg.sv
// Shared definitions for the JT51 register file: op codes, pipeline stage
// offsets, register field positions and the stage-to-slot helper.
package jt51_regs_pkg;

  typedef enum logic [1:0] {
    OP_M1 = 2'd0,
    OP_M2 = 2'd1,
    OP_C1 = 2'd2,
    OP_C2 = 2'd3
  } op_e;

  // Stage _N looks back N-1 slots from the live counter
  localparam logic [4:0] ST_I   = 5'd0;
  localparam logic [4:0] ST_II  = 5'd1;
  localparam logic [4:0] ST_III = 5'd2;
  localparam logic [4:0] ST_VI  = 5'd5;
  localparam logic [4:0] ST_VII = 5'd6;

  localparam int unsigned RL_LSB   = 6;
  localparam int unsigned FB_LSB   = 3;
  localparam int unsigned PMS_LSB  = 4;
  localparam int unsigned DT1_LSB  = 4;
  localparam int unsigned KF_LSB   = 2;
  localparam int unsigned HI2_LSB  = 6;
  localparam int unsigned D1L_LSB  = 4;
  localparam int unsigned KON_M1   = 3;
  localparam int unsigned KON_C1   = 4;
  localparam int unsigned KON_M2   = 5;
  localparam int unsigned KON_C2   = 6;

  function automatic logic [4:0] stage_slot(input logic [4:0] cyc, input logic [4:0] ofs);
    return cyc - ofs;
  endfunction

endpackage

// File: rtl/jt51_regs_seq.sv
// 5-bit operator slot counter with operator/phase decode.
module jt51_regs_seq
  import jt51_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen_i,
  output logic [4:0] cycles_o,
  output logic [1:0] cur_op_o,
  output logic       zero_o,
  output logic       half_o,
  output logic       m1_enters_o,
  output logic       m2_enters_o,
  output logic       c1_enters_o,
  output logic       c2_enters_o
);

  logic [4:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (cen_i) cyc_d = cyc_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycles_o    = cyc_q;
  assign cur_op_o    = cyc_q[4:3];
  assign zero_o      = (cyc_q == 5'd0);
  assign half_o      = (cyc_q[3:0] == 4'd0);
  assign m1_enters_o = (cur_op_o == OP_M1);
  assign m2_enters_o = (cur_op_o == OP_M2);
  assign c1_enters_o = (cur_op_o == OP_C1);
  assign c2_enters_o = (cur_op_o == OP_C2);

endmodule

// File: rtl/jt51_regs.sv
// JT51 per-slot parameter store, slot sequencer and connection/key-on decode.
module jt51_regs
  import jt51_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       up_rl,
  input  logic       up_kc,
  input  logic       up_kf,
  input  logic       up_pms,
  input  logic       up_dt1,
  input  logic       up_tl,
  input  logic       up_ks,
  input  logic       up_amsen,
  input  logic       up_dt2,
  input  logic       up_d1l,
  input  logic       up_keyon,
  input  logic [1:0] op,
  input  logic [2:0] ch,
  input  logic       csm,
  input  logic       overflow_A,
  output logic [1:0] rl_I,
  output logic [2:0] fb_II,
  output logic [2:0] con_I,
  output logic [6:0] kc_I,
  output logic [5:0] kf_I,
  output logic [2:0] pms_I,
  output logic [1:0] ams_VII,
  output logic [2:0] dt1_II,
  output logic [1:0] dt2_I,
  output logic [3:0] mul_VI,
  output logic [6:0] tl_VII,
  output logic [1:0] ks_III,
  output logic [4:0] arate_II,
  output logic       amsen_VII,
  output logic [4:0] rate1_II,
  output logic [4:0] rate2_II,
  output logic [3:0] rrate_II,
  output logic [3:0] d1l_I,
  output logic       keyon_II,
  output logic [1:0] cur_op,
  output logic [4:0] cycles,
  output logic       zero,
  output logic       half,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       op31_no,
  output logic       op31_acc,
  output logic       use_prevprev1,
  output logic       use_internal_x,
  output logic       use_internal_y,
  output logic       use_prev2,
  output logic       use_prev1
);

  jt51_regs_seq u_seq (
    .clk         (clk),
    .rst         (rst),
    .cen_i       (cen),
    .cycles_o    (cycles),
    .cur_op_o    (cur_op),
    .zero_o      (zero),
    .half_o      (half),
    .m1_enters_o (m1_enters),
    .m2_enters_o (m2_enters),
    .c1_enters_o (c1_enters),
    .c2_enters_o (c2_enters)
  );

  logic [1:0] rl_q  [8];
  logic [2:0] fb_q  [8];
  logic [2:0] con_q [8];
  logic [6:0] kc_q  [8];
  logic [5:0] kf_q  [8];
  logic [2:0] pms_q [8];
  logic [1:0] ams_q [8];

  logic [2:0] dt1_q   [32];
  logic [3:0] mul_q   [32];
  logic [6:0] tl_q    [32];
  logic [1:0] ks_q    [32];
  logic [4:0] ar_q    [32];
  logic       amsen_q [32];
  logic [4:0] d1r_q   [32];
  logic [1:0] dt2_q   [32];
  logic [4:0] d2r_q   [32];
  logic [3:0] d1l_q   [32];
  logic [3:0] rr_q    [32];
  logic       kon_q   [32];

  logic [5:0] csm_cnt_q, csm_cnt_d;
  logic       csm_force;
  logic [4:0] wslot;
  logic [2:0] kch;

  assign wslot = {op, ch};
  assign kch   = din[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rl_q  <= '{default: '0};
      fb_q  <= '{default: '0};
      con_q <= '{default: '0};
      kc_q  <= '{default: '0};
      kf_q  <= '{default: '0};
      pms_q <= '{default: '0};
      ams_q <= '{default: '0};
    end else begin
      if (up_rl) begin
        rl_q[ch]  <= din[RL_LSB +: 2];
        fb_q[ch]  <= din[FB_LSB +: 3];
        con_q[ch] <= din[2:0];
      end
      if (up_kc) kc_q[ch] <= din[6:0];
      if (up_kf) kf_q[ch] <= din[KF_LSB +: 6];
      if (up_pms) begin
        pms_q[ch] <= din[PMS_LSB +: 3];
        ams_q[ch] <= din[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt1_q   <= '{default: '0};
      mul_q   <= '{default: '0};
      tl_q    <= '{default: '0};
      ks_q    <= '{default: '0};
      ar_q    <= '{default: '0};
      amsen_q <= '{default: '0};
      d1r_q   <= '{default: '0};
      dt2_q   <= '{default: '0};
      d2r_q   <= '{default: '0};
      d1l_q   <= '{default: '0};
      rr_q    <= '{default: '0};
      kon_q   <= '{default: '0};
    end else begin
      if (up_dt1) begin
        dt1_q[wslot] <= din[DT1_LSB +: 3];
        mul_q[wslot] <= din[3:0];
      end
      if (up_tl) tl_q[wslot] <= din[6:0];
      if (up_ks) begin
        ks_q[wslot] <= din[HI2_LSB +: 2];
        ar_q[wslot] <= din[4:0];
      end
      if (up_amsen) begin
        amsen_q[wslot] <= din[7];
        d1r_q[wslot]   <= din[4:0];
      end
      if (up_dt2) begin
        dt2_q[wslot] <= din[HI2_LSB +: 2];
        d2r_q[wslot] <= din[4:0];
      end
      if (up_d1l) begin
        d1l_q[wslot] <= din[D1L_LSB +: 4];
        rr_q[wslot]  <= din[3:0];
      end
      // Key-on bit order in the data byte is M1, C1, M2, C2
      if (up_keyon) begin
        kon_q[{OP_M1, kch}] <= din[KON_M1];
        kon_q[{OP_C1, kch}] <= din[KON_C1];
        kon_q[{OP_M2, kch}] <= din[KON_M2];
        kon_q[{OP_C2, kch}] <= din[KON_C2];
      end
    end
  end

  // CSM holds key-on forced for the 32 slots following the triggering cen
  always_comb begin
    csm_cnt_d = csm_cnt_q;
    if (cen) begin
      if (csm && overflow_A)    csm_cnt_d = 6'd32;
      else if (csm_cnt_q != '0) csm_cnt_d = csm_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csm_cnt_q <= '0;
    else     csm_cnt_q <= csm_cnt_d;
  end

  assign csm_force = (csm_cnt_q != '0);

  logic [4:0] s_i, s_ii, s_iii, s_vi, s_vii;

  assign s_i   = stage_slot(cycles, ST_I);
  assign s_ii  = stage_slot(cycles, ST_II);
  assign s_iii = stage_slot(cycles, ST_III);
  assign s_vi  = stage_slot(cycles, ST_VI);
  assign s_vii = stage_slot(cycles, ST_VII);

  assign rl_I      = rl_q[s_i[2:0]];
  assign fb_II     = fb_q[s_ii[2:0]];
  assign con_I     = con_q[s_i[2:0]];
  assign kc_I      = kc_q[s_i[2:0]];
  assign kf_I      = kf_q[s_i[2:0]];
  assign pms_I     = pms_q[s_i[2:0]];
  assign ams_VII   = ams_q[s_vii[2:0]];

  assign dt1_II    = dt1_q[s_ii];
  assign dt2_I     = dt2_q[s_i];
  assign mul_VI    = mul_q[s_vi];
  assign tl_VII    = tl_q[s_vii];
  assign ks_III    = ks_q[s_iii];
  assign arate_II  = ar_q[s_ii];
  assign amsen_VII = amsen_q[s_vii];
  assign rate1_II  = d1r_q[s_ii];
  assign rate2_II  = d2r_q[s_ii];
  assign rrate_II  = rr_q[s_ii];
  assign d1l_I     = d1l_q[s_i];
  assign keyon_II  = kon_q[s_ii] | csm_force;

  assign op31_acc = c2_enters
                  | (c1_enters & (con_I >= 3'd4))
                  | (m2_enters & (con_I >= 3'd5))
                  | (m1_enters & (con_I == 3'd7));
  assign op31_no  = ~op31_acc;

  assign use_prevprev1  = m1_enters | (m2_enters & (con_I == 3'd5));
  assign use_internal_x = c2_enters & (con_I == 3'd2);
  assign use_internal_y = c2_enters & (con_I <= 3'd2);
  assign use_prev2      = (m2_enters & (con_I <= 3'd2)) | (c2_enters & (con_I == 3'd3));
  assign use_prev1      = (c1_enters & ((con_I == 3'd0) | (con_I == 3'd3) | (con_I == 3'd4)))
                        | (m2_enters & (con_I == 3'd1))
                        | (c2_enters & (con_I == 3'd5));

endmodule

// File: tb/tb_jt51_regs.sv
// Self-checking bench for jt51_regs: directed scenarios plus random register
// traffic compared against a per-channel/per-slot behavioural model.
module tb_jt51_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [7:0]  din = '0;
  logic [10:0] upv = '0;
  logic [1:0]  op = '0;
  logic [2:0]  ch = '0;
  logic        csm = 1'b0;
  logic        overflow_A = 1'b0;

  logic [1:0] rl_I;   logic [2:0] fb_II;  logic [2:0] con_I;  logic [6:0] kc_I;
  logic [5:0] kf_I;   logic [2:0] pms_I;  logic [1:0] ams_VII;
  logic [2:0] dt1_II; logic [1:0] dt2_I;  logic [3:0] mul_VI; logic [6:0] tl_VII;
  logic [1:0] ks_III; logic [4:0] arate_II; logic amsen_VII;
  logic [4:0] rate1_II; logic [4:0] rate2_II; logic [3:0] rrate_II; logic [3:0] d1l_I;
  logic keyon_II;
  logic [1:0] cur_op; logic [4:0] cycles;
  logic zero, half, m1_enters, m2_enters, c1_enters, c2_enters, op31_no, op31_acc;
  logic use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1;

  jt51_regs dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din),
    .up_rl(upv[0]), .up_kc(upv[1]), .up_kf(upv[2]), .up_pms(upv[3]),
    .up_dt1(upv[4]), .up_tl(upv[5]), .up_ks(upv[6]), .up_amsen(upv[7]),
    .up_dt2(upv[8]), .up_d1l(upv[9]), .up_keyon(upv[10]),
    .op(op), .ch(ch), .csm(csm), .overflow_A(overflow_A),
    .rl_I(rl_I), .fb_II(fb_II), .con_I(con_I), .kc_I(kc_I), .kf_I(kf_I),
    .pms_I(pms_I), .ams_VII(ams_VII), .dt1_II(dt1_II), .dt2_I(dt2_I),
    .mul_VI(mul_VI), .tl_VII(tl_VII), .ks_III(ks_III), .arate_II(arate_II),
    .amsen_VII(amsen_VII), .rate1_II(rate1_II), .rate2_II(rate2_II),
    .rrate_II(rrate_II), .d1l_I(d1l_I), .keyon_II(keyon_II),
    .cur_op(cur_op), .cycles(cycles), .zero(zero), .half(half),
    .m1_enters(m1_enters), .m2_enters(m2_enters), .c1_enters(c1_enters),
    .c2_enters(c2_enters), .op31_no(op31_no), .op31_acc(op31_acc),
    .use_prevprev1(use_prevprev1), .use_internal_x(use_internal_x),
    .use_internal_y(use_internal_y), .use_prev2(use_prev2), .use_prev1(use_prev1)
  );

  always #5 clk = ~clk;

  typedef struct { int rl, fb, con, kc, kf, pms, ams; } chan_t;
  typedef struct { int dt1, mul, tl, ks, ar, amsen, d1r, dt2, d2r, d1l, rr, kon; } oper_t;

  chan_t chm [8];
  oper_t opm [32];
  int    mcyc;
  int    csm_left;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++)  chm[i] = '{default: 0};
    for (int i = 0; i < 32; i++) opm[i] = '{default: 0};
    mcyc = 0;
    csm_left = 0;
  endtask

  // Operators that sum into the output, per algorithm (bit = M1,M2,C1,C2)
  function automatic int carriers(input int con);
    case (con)
      4:       return 12;
      5, 6:    return 14;
      7:       return 15;
      default: return 8;
    endcase
  endfunction

  task automatic model_edge(input bit c);
    int d, cc, s, k;
    d = int'(din); cc = int'(ch); s = int'(op) * 8 + cc; k = d % 8;
    if (upv[0])  begin chm[cc].rl = d / 64; chm[cc].fb = (d / 8) % 8; chm[cc].con = d % 8; end
    if (upv[1])  chm[cc].kc = d % 128;
    if (upv[2])  chm[cc].kf = d / 4;
    if (upv[3])  begin chm[cc].pms = (d / 16) % 8; chm[cc].ams = d % 4; end
    if (upv[4])  begin opm[s].dt1 = (d / 16) % 8; opm[s].mul = d % 16; end
    if (upv[5])  opm[s].tl = d % 128;
    if (upv[6])  begin opm[s].ks = d / 64; opm[s].ar = d % 32; end
    if (upv[7])  begin opm[s].amsen = d / 128; opm[s].d1r = d % 32; end
    if (upv[8])  begin opm[s].dt2 = d / 64; opm[s].d2r = d % 32; end
    if (upv[9])  begin opm[s].d1l = d / 16; opm[s].rr = d % 16; end
    if (upv[10]) begin
      opm[k].kon      = (d / 8) % 2;
      opm[16 + k].kon = (d / 16) % 2;
      opm[8 + k].kon  = (d / 32) % 2;
      opm[24 + k].kon = (d / 64) % 2;
    end
    if (c) begin
      if (csm && overflow_A) csm_left = 32;
      else if (csm_left > 0) csm_left--;
      mcyc = (mcyc + 1) % 32;
    end
  endtask

  task automatic check_all();
    int s1, s2, s3, s6, s7, cop, con, acc;
    s1 = mcyc; s2 = (mcyc + 31) % 32; s3 = (mcyc + 30) % 32;
    s6 = (mcyc + 27) % 32; s7 = (mcyc + 26) % 32;
    cop = mcyc / 8; con = chm[mcyc % 8].con;
    acc = (carriers(con) >> cop) % 2;
    chk("rl_I", rl_I, chm[s1 % 8].rl);       chk("fb_II", fb_II, chm[s2 % 8].fb);
    chk("con_I", con_I, chm[s1 % 8].con);    chk("kc_I", kc_I, chm[s1 % 8].kc);
    chk("kf_I", kf_I, chm[s1 % 8].kf);       chk("pms_I", pms_I, chm[s1 % 8].pms);
    chk("ams_VII", ams_VII, chm[s7 % 8].ams);
    chk("dt1_II", dt1_II, opm[s2].dt1);      chk("dt2_I", dt2_I, opm[s1].dt2);
    chk("mul_VI", mul_VI, opm[s6].mul);      chk("tl_VII", tl_VII, opm[s7].tl);
    chk("ks_III", ks_III, opm[s3].ks);       chk("arate_II", arate_II, opm[s2].ar);
    chk("amsen_VII", amsen_VII, opm[s7].amsen);
    chk("rate1_II", rate1_II, opm[s2].d1r);  chk("rate2_II", rate2_II, opm[s2].d2r);
    chk("rrate_II", rrate_II, opm[s2].rr);   chk("d1l_I", d1l_I, opm[s1].d1l);
    chk("keyon_II", keyon_II, (opm[s2].kon != 0) || (csm_left > 0));
    chk("cycles", cycles, mcyc);             chk("cur_op", cur_op, cop);
    chk("zero", zero, mcyc == 0);            chk("half", half, mcyc % 16 == 0);
    chk("m1_enters", m1_enters, cop == 0);   chk("m2_enters", m2_enters, cop == 1);
    chk("c1_enters", c1_enters, cop == 2);   chk("c2_enters", c2_enters, cop == 3);
    chk("op31_acc", op31_acc, acc);          chk("op31_no", op31_no, acc == 0);
    chk("use_prevprev1", use_prevprev1, cop == 0 || (cop == 1 && con == 5));
    chk("use_internal_x", use_internal_x, cop == 3 && con == 2);
    chk("use_internal_y", use_internal_y, cop == 3 && con <= 2);
    chk("use_prev2", use_prev2, (cop == 1 && con <= 2) || (cop == 3 && con == 3));
    chk("use_prev1", use_prev1, (cop == 2 && (con == 0 || con == 3 || con == 4)) ||
                                (cop == 1 && con == 1) || (cop == 3 && con == 5));
  endtask

  task automatic step(input bit c);
    cen = c;
    @(posedge clk);
    model_edge(c);
    #1;
    check_all();
  endtask

  task automatic write1(input int f, input logic [1:0] o, input logic [2:0] c, input logic [7:0] d);
    upv = '0; upv[f] = 1'b1; op = o; ch = c; din = d;
    step(1'b0);
    upv = '0;
  endtask

  initial begin
    model_clear();
    #2;
    check_all();
    chk("reset_zero", zero, 1'b1);
    chk("reset_m1", m1_enters, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step(1'b1);
    chk("half_16", half, 1'b1);
    chk("zero_16", zero, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1);

    write1(1, 2'd0, 3'd3, 8'h4A);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      chk("kc_dir", kc_I, (cycles[2:0] == 3'd3) ? 32'h4A : 32'h0);
    end

    write1(5, 2'd2, 3'd5, 8'h7F);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      chk("tl_dir", tl_VII, (mcyc == 27) ? 32'h7F : 32'h0);
    end

    write1(10, 2'd0, 3'd0, 8'h7B);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      chk("keyon_dir", keyon_II, mcyc == 4 || mcyc == 12 || mcyc == 20 || mcyc == 28);
    end
    write1(10, 2'd0, 3'd0, 8'h03);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      chk("keyon_off", keyon_II, 1'b0);
    end

    write1(0, 2'd0, 3'd0, 8'h07);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      if (mcyc % 8 == 0) chk("acc_con7", op31_acc, 1'b1);
    end
    write1(0, 2'd0, 3'd0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      if (mcyc % 8 == 0) chk("acc_con0", op31_acc, mcyc == 24);
    end

    while (mcyc != 31) step(1'b1);
    csm = 1'b1; overflow_A = 1'b1;
    step(1'b1);
    overflow_A = 1'b0;
    chk("csm_first", keyon_II, 1'b1);
    for (int i = 0; i < 31; i++) begin
      step(1'b1);
      chk("csm_round", keyon_II, 1'b1);
    end
    step(1'b1);
    chk("csm_release", keyon_II, 1'b0);
    csm = 1'b0;

    for (int i = 0; i < 700; i++) begin
      if ($urandom % 3 != 0) begin
        upv = 11'(1) << ($urandom % 11);
        op = 2'($urandom); ch = 3'($urandom); din = 8'($urandom);
      end else if ($urandom % 2 == 0) begin
        upv = '0;
      end
      csm = 1'($urandom);
      overflow_A = ($urandom % 40) == 0;
      step(($urandom % 4) != 0);
      if (i == 400) begin
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("midreset_cycles", cycles, 5'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt51_regs.md
# jt51_regs

Per-slot parameter store and slot sequencer for the JT51 FM core. Holds all channel (8) and operator (32) parameters written through the memory-mapped register front end. Cycles through the 32 operator slots on every `cen`, presenting each slot's parameters at the pipeline stage named by the output suffix. Also decodes the connection (algorithm) routing and key-on state, including CSM key-on.

## Interface
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  slot advance enable
- din  in  8  data byte of the last register write
- up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon  in  1 each  update-type levels, one-hot or none
- op  in  2  target operator (0=M1, 1=M2, 2=C1, 3=C2); ch  in  3  target channel
- csm  in  1  CSM mode; overflow_A  in  1  timer A overflow
- rl_I 2, fb_II 3, con_I 3, kc_I 7, kf_I 6, pms_I 3, ams_VII 2  out  channel parameters
- dt1_II 3, dt2_I 2, mul_VI 4, tl_VII 7, ks_III 2, arate_II 5, amsen_VII 1, rate1_II 5, rate2_II 5, rrate_II 4, d1l_I 4, keyon_II 1  out  operator parameters
- cur_op 2, cycles 5, zero, half, m1_enters, m2_enters, c1_enters, c2_enters, op31_no, op31_acc  out  sequencing
- use_prevprev1, use_internal_x, use_internal_y, use_prev2, use_prev1  out  operator modulation select

## Operation
- Slot index s = {op, ch}. Channel storage is indexed by ch; operator storage by s.
- Field map, applied when the flag is high:
  - up_rl: rl=din[7:6], fb=din[5:3], con=din[2:0]
  - up_kc: kc=din[6:0]
  - up_kf: kf=din[7:2]
  - up_pms: pms=din[6:4], ams=din[1:0]
  - up_dt1: dt1=din[6:4], mul=din[3:0]
  - up_tl: tl=din[6:0]
  - up_ks: ks=din[7:6], ar=din[4:0]
  - up_amsen: amsen=din[7], d1r=din[4:0]
  - up_dt2: dt2=din[7:6], d2r=din[4:0]
  - up_d1l: d1l=din[7:4], rr=din[3:0]
- Flags are levels that may stay high until the next write. Re-applying the same data is idempotent.
- up_keyon: channel k=din[2:0]. Key-on bits: M1=din[3], C1=din[4], M2=din[5], C2=din[6]. Ignores op/ch.
- CSM: a cen with csm&overflow_A forces key-on for the next 32 slots. keyon = kon[s] | csm_force.
- Output staging: an output with suffix _N shows the parameter of slot (cycles−(N−1)) mod 32. Channel outputs use the low 3 bits of that slot.
- Sequencing:
  - cur_op = cycles[4:3].
  - x_enters = (cur_op == op code of x).
  - zero = (cycles==0); half = (cycles[3:0]==0).
- con below is con_I of the current slot's channel.
- Carrier decode: op31_acc = c2_enters | (c1_enters & con≥4) | (m2_enters & con≥5) | (m1_enters & con==7). op31_no = !op31_acc.
- Modulation decode:
  - use_prevprev1 = m1_enters | (m2_enters & con==5)
  - use_internal_x = c2_enters & con==2
  - use_internal_y = c2_enters & con≤2
  - use_prev2 = (m2_enters & con≤2) | (c2_enters & con==3)
  - use_prev1 = (c1_enters & (con==0|con==3|con==4)) | (m2_enters & con==1) | (c2_enters & con==5)

## Timing
- Reset: cycles=0; all storage, kon and csm_force cleared; every parameter output 0; zero=half=m1_enters=1.
- cycles increments (wraps 31→0) only on clk edges with cen=1.
- Updates are written on any clk edge where the flag is high (cen not required). They are visible the first time the target slot reaches the output stage.
- A simultaneous update and CSM trigger on the same edge: both take effect.
- Reset mid-round restarts at slot 0.

## Structure
- Shared package: stage offsets, register field positions, op codes (M1=0, M2=1, C1=2, C2=3).
- Natural sub-module: jt51_regs_seq (5-bit slot counter plus enters/zero/half decode).
- Debug slot demux (sep32/sep32_cnt-style) is simulation-only and out of scope.

## Test plan
- Reset → cycles=0, zero=1, all parameter outputs 0; after 16 cen → half=1, zero=0.
- up_kc, ch=3, din=0x4A → kc_I==0x4A exactly while cycles[2:0]==3.
- up_tl, op=2, ch=5, din=0x7F → tl_VII==0x7F when cycles==(21+6)%32=27, 0 on other cycles.
- up_keyon, din=0x7B (ch3, all ops) → keyon_II=1 at cycles 4, 12, 20, 28; din=0x03 clears it.
- up_rl, ch=0, din=0x07 (con7) → op31_acc=1 at cycles 0, 8, 16, 24; con=0 → op31_acc only at 24.
- csm=1 with overflow_A pulse → keyon_II=1 for all 32 slots of the following round, then returns to kon.
